// File: rtl/pc_write_controller_pkg.sv
// Shared definitions for the PC write-side controller: FSM encoding and vector defaults.
package pc_write_controller_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0004;
  localparam int unsigned DEF_INCR         = 1;

endpackage

// File: rtl/pc_write_controller_pending_buf.sv
// One-entry redirect buffer used while the pipeline is stalled.
// Exceptions overwrite any entry; a plain redirect never displaces a pending exception.
module pc_pending_buf
  import pc_write_controller_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             exc_valid,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             capture,
  input  logic             drain,
  output logic             merged_v,
  output logic [WIDTH-1:0] merged_target
);

  logic             pend_v;
  logic             pend_exc;
  logic [WIDTH-1:0] pend_target;
  logic             merged_exc;

  // merged_* is the entry as it stands after this cycle's requests are folded in
  always_comb begin
    merged_v      = pend_v;
    merged_exc    = pend_exc;
    merged_target = pend_target;
    if (exc_valid) begin
      merged_v      = 1'b1;
      merged_exc    = 1'b1;
      merged_target = EXC_VECTOR;
    end else if (redirect_valid && !(pend_v && pend_exc)) begin
      merged_v      = 1'b1;
      merged_exc    = 1'b0;
      merged_target = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pend_v      <= 1'b0;
      pend_exc    <= 1'b0;
      pend_target <= '0;
    end else if (drain) begin
      pend_v   <= 1'b0;
      pend_exc <= 1'b0;
    end else if (capture) begin
      pend_v      <= merged_v;
      pend_exc    <= merged_exc;
      pend_target <= merged_target;
    end
  end

endmodule

// File: rtl/pc_write_controller.sv
// Write-side controller for the falling-edge PC register: boot, sequential fetch,
// stalls, branch redirects and exception entry. All outputs are registered.
module pc_write_controller
  import pc_write_controller_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned      INCR         = DEF_INCR
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_w_en,
  output logic             pc_r_en,
  output logic             fetch_valid,
  output logic             flush
);

  pc_state_e        state;
  logic             active;
  logic             take;
  logic             merged_v;
  logic [WIDTH-1:0] merged_target;

  assign active = (state != ST_BOOT);
  assign take   = active && !stall && merged_v;

  // Buffer fills during stall and empties on the first unstalled cycle (its entry is taken then)
  pc_pending_buf #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pend (
    .clk             (clk),
    .clr_n           (clr_n),
    .exc_valid       (exc_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .capture         (active && stall),
    .drain           (active && !stall),
    .merged_v        (merged_v),
    .merged_target   (merged_target)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= ST_BOOT;
      pc_next     <= RESET_VECTOR;
      pc_w_en     <= 1'b1;
      pc_r_en     <= 1'b0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
    end else begin
      pc_r_en <= 1'b1;
      pc_w_en <= 1'b0;
      flush   <= 1'b0;
      if (state == ST_BOOT) begin
        state       <= ST_RUN;
        pc_next     <= RESET_VECTOR;
        pc_w_en     <= 1'b1;
        fetch_valid <= 1'b1;
      end else if (take) begin
        state       <= ST_REDIRECT;
        pc_next     <= merged_target;
        pc_w_en     <= 1'b1;
        flush       <= 1'b1;
        fetch_valid <= 1'b0;
      end else if (stall) begin
        state       <= ST_HOLD;
        fetch_valid <= 1'b0;
      end else if (state == ST_REDIRECT) begin
        // Target was never fetched yet: hold it one cycle before incrementing
        state       <= ST_RUN;
        fetch_valid <= 1'b1;
      end else if (fetch_ready) begin
        state       <= ST_RUN;
        pc_next     <= pc_cur + WIDTH'(INCR);
        pc_w_en     <= 1'b1;
        fetch_valid <= 1'b1;
      end else begin
        state       <= ST_HOLD;
        fetch_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_write_controller.sv
// Self-checking bench for pc_write_controller: directed scenarios then randomized traffic,
// with the falling-edge PC register modelled in the environment.
module tb_pc_write_controller;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] pc_cur;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        fetch_ready;
  logic [31:0] pc_next;
  logic        pc_w_en;
  logic        pc_r_en;
  logic        fetch_valid;
  logic        flush;

  logic [31:0] pc_reg;
  int          writes_80 = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  logic        m_boot, m_after_redir, m_pend_v, m_pend_exc;
  logic [31:0] m_pend_t, m_pc;
  logic [31:0] e_next;
  logic        e_w, e_r, e_fv, e_fl;

  pc_write_controller #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .INCR         (1)
  ) dut (
    .clk             (clk),
    .clr_n           (clr_n),
    .pc_cur          (pc_cur),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .fetch_ready     (fetch_ready),
    .pc_next         (pc_next),
    .pc_w_en         (pc_w_en),
    .pc_r_en         (pc_r_en),
    .fetch_valid     (fetch_valid),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  // PC register: written on the falling edge, read back only while enabled
  assign pc_cur = pc_r_en ? pc_reg : 32'hDEAD_BEEF;
  always @(negedge clk) begin
    if (pc_w_en) begin
      pc_reg <= pc_next;
      if (pc_next == 32'h80) writes_80 <= writes_80 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_checks++;
    if (got !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
    end
  endtask

  task automatic model_reset();
    e_next = RV; e_w = 1'b1; e_r = 1'b0; e_fv = 1'b0; e_fl = 1'b0;
    m_boot = 1'b1; m_after_redir = 1'b0;
    m_pend_v = 1'b0; m_pend_exc = 1'b0; m_pend_t = '0;
    m_pc = RV;
  endtask

  // One clock of the behavioural rules: which PC (if any) gets written this cycle
  task automatic model_step();
    logic        cv, cx;
    logic [31:0] ct;
    if (!clr_n) begin
      model_reset();
      return;
    end
    e_r = 1'b1; e_w = 1'b0; e_fl = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      e_next = RV; e_w = 1'b1; e_fv = 1'b1;
    end else begin
      cv = m_pend_v; cx = m_pend_exc; ct = m_pend_t;
      if (exc_valid) begin
        cv = 1'b1; cx = 1'b1; ct = EV;
      end else if (redirect_valid && !(m_pend_v && m_pend_exc)) begin
        cv = 1'b1; cx = 1'b0; ct = redirect_target;
      end
      if (!stall && cv) begin
        e_next = ct; e_w = 1'b1; e_fl = 1'b1; e_fv = 1'b0;
        m_pend_v = 1'b0; m_pend_exc = 1'b0; m_after_redir = 1'b1;
      end else if (stall) begin
        m_pend_v = cv; m_pend_exc = cx; m_pend_t = ct;
        e_fv = 1'b0; m_after_redir = 1'b0;
      end else if (m_after_redir) begin
        e_fv = 1'b1; m_after_redir = 1'b0;
      end else begin
        e_fv = 1'b1;
        if (fetch_ready) begin
          e_next = m_pc + 32'd1; e_w = 1'b1;
        end
      end
    end
    if (e_w) m_pc = e_next;
  endtask

  task automatic check_outputs();
    check("pc_next", pc_next, e_next);
    check("pc_w_en", 32'(pc_w_en), 32'(e_w));
    check("pc_r_en", 32'(pc_r_en), 32'(e_r));
    check("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    check("flush", 32'(flush), 32'(e_fl));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic set_idle();
    stall = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
    fetch_ready = 1'b1; redirect_target = '0;
  endtask

  task automatic run_until_written(input logic [31:0] pc, input string tag);
    for (int n = 0; n < 40 && !(pc_w_en && pc_next == pc); n++) cycle();
    check(tag, pc_next, pc);
  endtask

  initial begin
    int snap;
    set_idle();
    model_reset();
    clr_n = 1'b1;
    #1 clr_n = 1'b0;
    #1 check_outputs();

    // 1. reset then sequential run
    repeat (3) cycle();
    clr_n = 1'b1;
    cycle();
    check("boot_pc", pc_next, RV);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("run_seq", pc_next, 32'(i));
      check("run_flush", 32'(flush), 32'd0);
    end

    // 2. stall at pc 5
    run_until_written(32'd5, "reach_pc5");
    stall = 1'b1;
    repeat (4) begin
      cycle();
      check("stall_fv", 32'(fetch_valid), 32'd0);
    end
    stall = 1'b0;
    cycle();
    check("stall_release", pc_next, 32'd6);

    // 3. redirect at pc 8
    run_until_written(32'd8, "reach_pc8");
    redirect_valid = 1'b1; redirect_target = 32'h40;
    cycle();
    check("redir_pc", pc_next, 32'h40);
    check("redir_flush", 32'(flush), 32'd1);
    set_idle();
    cycle();
    check("redir_flush_once", 32'(flush), 32'd0);
    cycle();
    check("redir_inc", pc_next, 32'h41);

    // 4a. redirect during stall, later exception wins
    snap = writes_80;
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    exc_valid = 1'b1;
    cycle();
    exc_valid = 1'b0;
    cycle();
    stall = 1'b0;
    cycle();
    check("pend_exc_pc", pc_next, EV);
    check("pend_exc_flush", 32'(flush), 32'd1);
    repeat (2) cycle();
    check("no_80_write", 32'(writes_80 - snap), 32'd0);

    // 4b. same-cycle exception and redirect
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h123;
    cycle();
    check("exc_over_redir", pc_next, EV);
    set_idle();
    cycle();

    // 5. wrap, then async reset mid-redirect
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    cycle();
    set_idle();
    repeat (2) cycle();
    check("wrap", pc_next, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    cycle();
    check("in_redirect", 32'(flush), 32'd1);
    set_idle();
    #1 clr_n = 1'b0;
    #1;
    check("async_pc_next", pc_next, RV);
    check("async_w_en", 32'(pc_w_en), 32'd1);
    check("async_r_en", 32'(pc_r_en), 32'd0);
    check("async_fv", 32'(fetch_valid), 32'd0);
    check("async_flush", 32'(flush), 32'd0);
    model_reset();
    repeat (2) cycle();
    clr_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall           = ($urandom_range(0, 9) < 3);
      fetch_ready     = ($urandom_range(0, 9) < 8);
      exc_valid       = ($urandom_range(0, 19) == 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom();
      clr_n           = ($urandom_range(0, 149) != 0);
      cycle();
    end
    clr_n = 1'b1;
    set_idle();
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
